// File: rtl/spi_load_slave_rx_pkg.sv
// Package for the SPI/QPI load-file slave receiver.
// Holds the command codes, the field widths and the frame-decoder state encoding,
// plus a helper that returns the bit length of the field being received in a state.
package spi_load_pkg;

    localparam logic [7:0]  CMD_WR_REG = 8'h01;
    localparam logic [7:0]  CMD_WR_MEM = 8'h02;
    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned WORD_BITS  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_REG,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } state_e;

    // Command and register-value fields are one byte; address and data are one word.
    function automatic logic [5:0] field_bits(state_e s);
        return (s == ST_CMD || s == ST_REG) ? 6'(CMD_BITS) : 6'(WORD_BITS);
    endfunction

endpackage

// File: rtl/spi_load_slave_rx_if.sv
// Memory write request bus produced by the SPI load slave receiver.
//   valid  request valid (held with addr/wdata until ready)
//   ready  request accepted when valid & ready
//   addr   32-bit write byte address
//   wdata  32-bit write data
// Modport master: receiver side. Modport slave: memory side.
interface spi_load_slave_rx_if;

    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;

    modport master (output valid, output addr, output wdata, input ready);
    modport slave  (input valid, input addr, input wdata, output ready);

endinterface

// File: rtl/spi_load_slave_rx_edge_sync.sv
// Synchronizer and edge detector for the SPI pins.
//   clk, rst_n     system clock, asynchronous active-low reset
//   sck_i, csn_i   raw SPI clock and chip select (async to clk)
//   sdi_i[3:0]     raw data lanes
//   sck_rise_o     1-cycle pulse on a rising edge of synchronized sck
//   csn_o          synchronized chip select level
//   csn_rise_o     1-cycle pulse when synchronized csn goes high
//   csn_fall_o     1-cycle pulse when synchronized csn goes low
//   sdi_o[3:0]     synchronized data lanes, aligned with sck_rise_o
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck_i,
    input  logic       csn_i,
    input  logic [3:0] sdi_i,
    output logic       sck_rise_o,
    output logic       csn_o,
    output logic       csn_rise_o,
    output logic       csn_fall_o,
    output logic [3:0] sdi_o
);

    // Bit layout of each stage: {sdi[3:0], csn, sck}. csn idles high.
    localparam logic [5:0] RST_VEC = 6'b00_0010;

    logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
    logic [1:0]                  prev_q, prev_d;
    logic [5:0]                  synced;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], {sdi_i, csn_i, sck_i}};
        synced = sync_q[SYNC_STAGES-1];
        prev_d = synced[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VEC}};
            prev_q <= RST_VEC[1:0];
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    always_comb begin
        sck_rise_o = synced[0] & ~prev_q[0];
        csn_o      = synced[1];
        csn_rise_o = synced[1] & ~prev_q[1];
        csn_fall_o = ~synced[1] & prev_q[1];
        sdi_o      = synced[5:2];
    end

endmodule

// File: rtl/spi_load_slave_rx.sv
// SPI/QPI slave receiver for load-file frames.
// Decodes cmd 0x01 (write config reg, bit0 = quad enable for later frames) and
// cmd 0x02 (32-bit address followed by a stream of 32-bit data words, one memory
// write per word, address advancing by ADDR_INC). Unknown commands are ignored.
//   clk, rst_n        system clock (>= 4x SCK), asynchronous active-low reset
//   spi_sck_i         SPI clock from master
//   spi_csn_i         chip select, active low
//   spi_sdi0..3_i     data lanes (lane 0 only in single mode; lane 3 is nibble MSB)
//   mem               memory write request bus (master side)
//   qpi_en_o          config reg bit0
//   busy_o            synchronized csn is low
//   frame_abort_o     1-cycle pulse: csn rose with a partial field received
//   overflow_o        sticky: a data word completed while a write was pending
module spi_load_slave_rx
    import spi_load_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_INC    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spi_sck_i,
    input  logic                       spi_csn_i,
    input  logic                       spi_sdi0_i,
    input  logic                       spi_sdi1_i,
    input  logic                       spi_sdi2_i,
    input  logic                       spi_sdi3_i,
    spi_load_slave_rx_if.master        mem,
    output logic                       qpi_en_o,
    output logic                       busy_o,
    output logic                       frame_abort_o,
    output logic                       overflow_o
);

    logic       sck_rise, csn_s, csn_rise, csn_fall;
    logic [3:0] sdi_s;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sck_i      (spi_sck_i),
        .csn_i      (spi_csn_i),
        .sdi_i      ({spi_sdi3_i, spi_sdi2_i, spi_sdi1_i, spi_sdi0_i}),
        .sck_rise_o (sck_rise),
        .csn_o      (csn_s),
        .csn_rise_o (csn_rise),
        .csn_fall_o (csn_fall),
        .sdi_o      (sdi_s)
    );

    state_e      state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        frame_quad_q, frame_quad_d;
    logic        qpi_en_q, qpi_en_d;
    logic [31:0] waddr_q, waddr_d;
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        abort_q, abort_d;
    logic        overflow_q, overflow_d;

    logic        sample;
    logic [31:0] shift_nxt;
    logic [5:0]  cnt_nxt;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        frame_quad_d = frame_quad_q;
        qpi_en_d     = qpi_en_q;
        waddr_d      = waddr_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        abort_d      = 1'b0;
        overflow_d   = overflow_q;

        sample    = sck_rise & ~csn_s;
        shift_nxt = frame_quad_q ? {shift_q[27:0], sdi_s} : {shift_q[30:0], sdi_s[0]};
        cnt_nxt   = cnt_q + (frame_quad_q ? 6'd4 : 6'd1);

        // The pending request is independent of the frame and survives csn rise.
        if (valid_q && mem.ready) begin
            valid_d = 1'b0;
        end

        if (csn_rise) begin
            if (state_q != ST_IDLE && state_q != ST_IGNORE && cnt_q != '0) begin
                abort_d = 1'b1;
            end
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_IDLE) begin
            if (csn_fall) begin
                // Lane width is frozen for the whole frame at its start.
                state_d      = ST_CMD;
                cnt_d        = '0;
                frame_quad_d = qpi_en_q;
            end
        end else if (sample && state_q != ST_IGNORE) begin
            shift_d = shift_nxt;
            if (cnt_nxt == field_bits(state_q)) begin
                cnt_d = '0;
                case (state_q)
                    ST_CMD: begin
                        if (shift_nxt[7:0] == CMD_WR_REG) begin
                            state_d = ST_REG;
                        end else if (shift_nxt[7:0] == CMD_WR_MEM) begin
                            state_d = ST_ADDR;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                    ST_REG: begin
                        qpi_en_d = shift_nxt[0];
                        state_d  = ST_IGNORE;
                    end
                    ST_ADDR: begin
                        waddr_d = shift_nxt;
                        state_d = ST_DATA;
                    end
                    ST_DATA: begin
                        if (valid_q) begin
                            overflow_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            addr_d  = waddr_q;
                            wdata_d = shift_nxt;
                        end
                        // Address advances even for a dropped word.
                        waddr_d = waddr_q + 32'(ADDR_INC);
                    end
                    default: ;
                endcase
            end else begin
                cnt_d = cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            frame_quad_q <= 1'b0;
            qpi_en_q     <= 1'b0;
            waddr_q      <= '0;
            valid_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            abort_q      <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            frame_quad_q <= frame_quad_d;
            qpi_en_q     <= qpi_en_d;
            waddr_q      <= waddr_d;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            abort_q      <= abort_d;
            overflow_q   <= overflow_d;
        end
    end

    assign mem.valid     = valid_q;
    assign mem.addr      = addr_q;
    assign mem.wdata     = wdata_q;
    assign qpi_en_o      = qpi_en_q;
    assign busy_o        = ~csn_s;
    assign frame_abort_o = abort_q;
    assign overflow_o    = overflow_q;

endmodule
